// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmit path.
//   DATA_W      : byte width presented to the xmit transmitter
//   tx_state_e  : sequencer states (IDLE/SEND/WAIT)
//   CR, LF      : line-ending characters used by the optional CR insertion
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } tx_state_e;

  localparam logic [DATA_W-1:0] CR = 8'h0D;
  localparam logic [DATA_W-1:0] LF = 8'h0A;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage for the transmit FIFO.
// Synchronous write, asynchronous read so the head byte is visible in the
// same cycle the sequencer decides to pop it.
//   clk     : write clock
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address
//   rdata_c : combinational read data at raddr
module fifo_ram
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is intentionally not reset; occupancy is tracked outside.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered byte source feeding the xmit UART transmitter.
// Producers push bytes at clock rate; a small sequencer pops them one at a
// time and handshakes with xmit through char/sendchar/busy.
// Optional build macro: UART_TX_FIFO_CRLF_EN inserts a CR before every LF.
// DEPTH must be a power of two (>= 2) with ADDR_W == log2(DEPTH).
//   clk      : system clock shared with xmit
//   reset    : asynchronous active-high reset
//   wr_data  : byte to enqueue
//   wr_en    : enqueue strobe
//   full     : occupancy == DEPTH
//   empty    : occupancy == 0
//   count    : occupancy, 0..DEPTH
//   overflow : sticky, set when a write was dropped
//   char     : byte presented to xmit
//   sendchar : transmit request to xmit
//   busy     : xmit busy
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [DATA_W-1:0] char,
  output logic              sendchar,
  input  logic              busy
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] char_q, char_d;
  logic              sendchar_q, sendchar_d;
`ifdef UART_TX_FIFO_CRLF_EN
  logic              cr_sent_q, cr_sent_d;
`endif

  logic              wr_ok;
  logic              pop;
  logic [DATA_W-1:0] head_c;

  fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (wr_ok),
    .waddr   (wr_ptr_q),
    .wdata   (wr_data),
    .raddr   (rd_ptr_q),
    .rdata_c (head_c)
  );

  // Next-state: write acceptance, pop sequencing and occupancy.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    char_d     = char_q;
    sendchar_d = sendchar_q;
    pop        = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
    cr_sent_d  = cr_sent_q;
`endif

    // Fullness is judged on the registered count, so a pop in the same
    // cycle cannot make room for a write to a full FIFO.
    wr_ok = wr_en && !full_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (wr_en && full_q) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          sendchar_d = 1'b1;
          state_d    = SEND;
`ifdef UART_TX_FIFO_CRLF_EN
          // LF at the head: emit a CR first and leave the LF queued.
          if ((head_c == LF) && !cr_sent_q) begin
            char_d    = CR;
            cr_sent_d = 1'b1;
          end else begin
            char_d    = head_c;
            pop       = 1'b1;
            cr_sent_d = 1'b0;
          end
`else
          char_d = head_c;
          pop    = 1'b1;
`endif
        end
      end
      SEND: begin
        if (busy) begin
          sendchar_d = 1'b0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // Returning through IDLE guarantees a quiet cycle before the next
        // request, so xmit never sees sendchar held across frames.
        if (!busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    count_d = count_q + CNT_W'(wr_ok) - CNT_W'(pop);
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      char_q     <= '0;
      sendchar_q <= 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
      cr_sent_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      char_q     <= char_d;
      sendchar_q <= sendchar_d;
`ifdef UART_TX_FIFO_CRLF_EN
      cr_sent_q  <= cr_sent_d;
`endif
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign char     = char_q;
  assign sendchar = sendchar_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural xmit busy model and a
// FIFO occupancy/order model checked on every falling edge.
module tb_uart_tx_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] char_o;
  logic       sendchar;
  logic       busy;

  int checks = 0;
  int errs   = 0;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .char     (char_o),
    .sendchar (sendchar),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // xmit busy model: busy rises 2 clocks after sendchar, holds 10 clocks.
  // busy_mode 1 forces busy high, 2 forces it low.
  logic [1:0] busy_mode;
  int         bph;
  int         bn;
  initial begin
    busy = 1'b0;
    bph  = 0;
    bn   = 0;
  end
  always @(posedge clk) begin
    #2;
    if (busy_mode == 2'd1) begin
      busy = 1'b1;
      bph  = 0;
    end else if (busy_mode == 2'd2 || reset) begin
      busy = 1'b0;
      bph  = 0;
    end else begin
      case (bph)
        0: begin
          busy = 1'b0;
          if (sendchar) begin
            bph = 1;
            bn  = 1;
          end
        end
        1: begin
          if (bn == 0) begin
            busy = 1'b1;
            bph  = 2;
            bn   = 9;
          end else bn--;
        end
        default: begin
          if (bn == 0) begin
            busy = 1'b0;
            bph  = 0;
          end else bn--;
        end
      endcase
    end
  end

  // Reference model of accepted bytes and occupancy.
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         acc;
  int         emit;
  bit         ovf_m;
  bit         cr_done;
  int         cyc;
  int         fall_cyc;
  logic       prev_sc;
  logic       prev_busy;
  logic [7:0] prev_char;

  initial begin
    acc = 0; emit = 0; ovf_m = 0; cr_done = 0; cyc = 0; fall_cyc = -100;
    prev_sc = 0; prev_busy = 0; prev_char = 0;
  end

  // Full is judged before this edge's pop: emit only counts earlier pops.
  always @(posedge clk) begin
    if (!reset && wr_en) begin
      if (acc - emit < 16) begin
        acc++;
        exp_q.push_back(wr_data);
      end else begin
        ovf_m = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_c;
    cyc++;
    if (reset) begin
      acc = 0; emit = 0; ovf_m = 0; cr_done = 0;
      exp_q.delete();
      prev_sc = 0; prev_busy = 0; prev_char = 0;
    end else begin
      if (prev_busy && !busy) fall_cyc = cyc;
      if (sendchar && !prev_sc) begin
        check("idle_gap", 32'(cyc - fall_cyc >= 2), 1);
        check("byte_queued", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
`ifdef UART_TX_FIFO_CRLF_EN
          if (exp_q[0] == 8'h0A && !cr_done) begin
            exp_c   = 8'h0D;
            cr_done = 1'b1;
          end else begin
            exp_c   = exp_q.pop_front();
            cr_done = 1'b0;
            emit++;
          end
`else
          exp_c = exp_q.pop_front();
          emit++;
`endif
          check("char_order", char_o, exp_c);
        end
        got_q.push_back(char_o);
      end
      if (prev_sc && !sendchar) check("sc_fall_after_busy", prev_busy, 1);
      if (prev_sc && sendchar) begin
        check("sc_hold_busy_low", prev_busy, 0);
        check("char_stable", char_o, prev_char);
      end
      check("count", count, acc - emit);
      check("full", full, 32'(acc - emit == 16));
      check("empty", empty, 32'(acc - emit == 0));
      check("overflow", overflow, ovf_m);
      prev_sc   = sendchar;
      prev_busy = busy;
      prev_char = char_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (k < max && !(count == 0 && !sendchar && !busy && bph == 0)) begin
      tick();
      k++;
    end
    check("idle_timeout", 32'(k < max), 1);
    tick();
    tick();
  endtask

  initial begin
    int k;
    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    busy_mode = 2'd0;
    tick();
    tick();
    check("rst_sendchar", sendchar, 0);
    check("rst_char", char_o, 8'h00);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    tick();

    // Single byte: latency and handshake.
    got_q.delete();
    wr_data = 8'h30; wr_en = 1'b1;
    tick();
    check("t1_count_n1", count, 1);
    check("t1_sc_n1", sendchar, 0);
    wr_en = 1'b0;
    tick();
    check("t1_sc_n2", sendchar, 1);
    check("t1_char_n2", char_o, 8'h30);
    check("t1_empty_n2", empty, 1);
    k = 0;
    while (!busy && k < 20) begin
      tick();
      k++;
    end
    check("t1_busy_seen", busy, 1);
    check("t1_sc_drop", sendchar, 0);
    wait_idle(100);
    check("t1_n_out", got_q.size(), 1);
    check("t1_out0", got_q[0], 8'h30);
    check("t1_overflow", overflow, 0);

    // Ten bytes back to back.
    got_q.delete();
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'(8'h30 + i); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    wait_idle(1000);
    check("t2_n_out", got_q.size(), 10);
    for (int i = 0; i < 10; i++) check("t2_out", got_q[i], 8'(8'h30 + i));
    check("t2_overflow", overflow, 0);

    // Fill with xmit stalled: 17th byte dropped.
    got_q.delete();
    busy_mode = 2'd1;
    wr_data = 8'hA0; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 17; i++) begin
      wr_data = 8'(8'h50 + i); wr_en = 1'b1;
      tick();
      if (i == 15) begin
        check("t3_full16", full, 1);
        check("t3_count16", count, 16);
        check("t3_ovf_before", overflow, 0);
      end
    end
    wr_en = 1'b0;
    check("t3_ovf_set", overflow, 1);
    check("t3_count17", count, 16);
    tick(); tick(); tick();
    check("t3_ovf_sticky", overflow, 1);
    busy_mode = 2'd0;
    wait_idle(2000);
    check("t3_n_out", got_q.size(), 17);
    check("t3_out_first", got_q[0], 8'hA0);
    for (int i = 0; i < 16; i++) check("t3_out", got_q[i+1], 8'(8'h50 + i));
    check("t3_ovf_end", overflow, 1);

    // 32 bytes across the pointer wrap, with a same-cycle write+pop.
    got_q.delete();
    wr_data = 8'h00; wr_en = 1'b1;
    tick();
    wr_data = 8'h01;
    tick();
    wr_en = 1'b0;
    check("t4_wr_pop_count", count, 1);
    check("t4_wr_pop_sc", sendchar, 1);
    check("t4_wr_pop_char", char_o, 8'h00);
    for (int b = 2; b < 32; b++) begin
      k = 0;
      while (full && k < 200) begin
        tick();
        k++;
      end
      check("t4_full_timeout", 32'(k < 200), 1);
      wr_data = 8'(b); wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
    end
    wait_idle(2000);
    check("t4_n_out", got_q.size(), 32);
    for (int i = 0; i < 32; i++) check("t4_out", got_q[i], 8'(i));

    // Asynchronous reset while SEND is pending with 5 bytes queued.
    busy_mode = 2'd2;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'(8'h70 + i); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    tick();
    check("t5_sc_pre", sendchar, 1);
    check("t5_count_pre", count, 5);
    check("t5_char_pre", char_o, 8'h70);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("t5_sc", sendchar, 0);
    check("t5_char", char_o, 8'h00);
    check("t5_count", count, 0);
    check("t5_empty", empty, 1);
    check("t5_full", full, 0);
    check("t5_overflow", overflow, 0);
    tick();
    reset = 1'b0;
    busy_mode = 2'd0;
    tick();
    tick();
    check("t5_sc_post", sendchar, 0);

    // LF handling.
    got_q.delete();
    wr_data = 8'h41; wr_en = 1'b1;
    tick();
    wr_data = 8'h0A;
    tick();
    wr_en = 1'b0;
    wait_idle(1000);
`ifdef UART_TX_FIFO_CRLF_EN
    check("t6_n_out", got_q.size(), 3);
    check("t6_out0", got_q[0], 8'h41);
    check("t6_out1", got_q[1], 8'h0D);
    check("t6_out2", got_q[2], 8'h0A);
`else
    check("t6_n_out", got_q.size(), 2);
    check("t6_out0", got_q[0], 8'h41);
    check("t6_out1", got_q[1], 8'h0A);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
